// File: rtl/stump_pkg.sv
// stump_pkg: shared definitions for the Stump control unit.
//   - FSM state encodings (FETCH=0, EXECUTE=1, MEMORY=2; 3 is unused)
//   - opcode constants ADD..BCC
//   - Bcc condition-code constants
//   - instruction field and flag bit indices
package stump_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEMORY  = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SBC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_LDST = 3'd6;
  localparam logic [2:0] OP_BCC  = 3'd7;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_NV = 4'h1;
  localparam logic [3:0] CC_HI = 4'h2;
  localparam logic [3:0] CC_LS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_CS = 4'h5;
  localparam logic [3:0] CC_NE = 4'h6;
  localparam logic [3:0] CC_EQ = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;
  localparam logic [3:0] CC_VS = 4'h9;
  localparam logic [3:0] CC_PL = 4'hA;
  localparam logic [3:0] CC_MI = 4'hB;
  localparam logic [3:0] CC_GE = 4'hC;
  localparam logic [3:0] CC_LT = 4'hD;
  localparam logic [3:0] CC_GT = 4'hE;
  localparam logic [3:0] CC_LE = 4'hF;

  // Instruction field indices
  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 13;
  localparam int TYPE_BIT = 12;
  localparam int S_BIT    = 11;  // S for ALU ops, L/S for LD/ST (0 = LD)
  localparam int COND_HI  = 11;
  localparam int COND_LO  = 8;

  // Flag indices within {N,Z,V,C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/stump_control_if.sv
// stump_control_if: memory handshake bundle between the control unit and memory.
//   mem_rdata  memory -> control  read data (instruction during FETCH)
//   mem_ack    memory -> control  access complete (honoured only with wait states)
//   mem_ren    control -> memory  read strobe
//   mem_wen    control -> memory  write strobe
//   addr_sel   control -> memory  address mux: 0 = PC, 1 = ALU result
// Handshake: a FETCH or MEMORY access is accepted in the cycle where the strobe
// is high and mem_ack is high (or every strobe cycle when wait states are off);
// strobes stay asserted and unchanged until acceptance.
interface stump_control_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_ren;
  logic              mem_wen;
  logic              addr_sel;

  modport master (input mem_rdata, input mem_ack,
                  output mem_ren, output mem_wen, output addr_sel);
  modport slave  (output mem_rdata, output mem_ack,
                  input mem_ren, input mem_wen, input addr_sel);
endinterface

// File: rtl/stump_cond_eval.sv
// stump_cond_eval: combinational Bcc condition evaluation.
//   cc    in  4  condition-code register {N,Z,V,C}
//   cond  in  4  condition field of the branch
//   taken out 1  condition holds
module stump_cond_eval
  import stump_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [3:0] cond,
  output logic       taken
);
  logic n, z, v, c;

  assign n = cc[FLAG_N];
  assign z = cc[FLAG_Z];
  assign v = cc[FLAG_V];
  assign c = cc[FLAG_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_AL: taken = 1'b1;
      CC_NV: taken = 1'b0;
      CC_HI: taken = c & ~z;
      CC_LS: taken = ~c | z;
      CC_CC: taken = ~c;
      CC_CS: taken = c;
      CC_NE: taken = ~z;
      CC_EQ: taken = z;
      CC_VC: taken = ~v;
      CC_VS: taken = v;
      CC_PL: taken = ~n;
      CC_MI: taken = n;
      CC_GE: taken = ~(n ^ v);
      CC_LT: taken = n ^ v;
      CC_GT: taken = ~z & ~(n ^ v);
      CC_LE: taken = z | (n ^ v);
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/stump_control.sv
// stump_control: Stump control unit and condition-code store.
// Sequences each instruction FETCH -> EXECUTE (-> MEMORY for LD/ST), decodes
// the instruction register into ALU and datapath controls, latches ALU flags
// into cc on S-instructions and evaluates Bcc conditions from cc.
// Optional feature: define STUMP_MEM_WAIT_EN to make FETCH/MEMORY wait for mem_ack.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   bus (master)         memory handshake: mem_rdata, mem_ack, mem_ren, mem_wen, addr_sel
//   alu_flags  in  4     ALU {N,Z,V,C}
//   state      out 2     FSM state (FETCH=0, EXECUTE=1, MEMORY=2)
//   ir         out 16    instruction register
//   pc_inc     out 1     PC increment (fetch accepted)
//   pc_load    out 1     PC load from ALU (branch taken)
//   reg_wen    out 1     register-bank write
//   wdata_sel  out 1     write-back source: 0 ALU, 1 mem_rdata
//   imm_sel    out 1     ALU operand B is the sign-extended immediate
//   alu_func   out 3     ALU function
//   alu_c_in   out 1     registered carry cc[0]
//   cc         out 4     condition-code register {N,Z,V,C}
module stump_control
  import stump_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  stump_control_if.master   bus,
  input  logic [3:0]        alu_flags,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] ir,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              reg_wen,
  output logic              wdata_sel,
  output logic              imm_sel,
  output logic [2:0]        alu_func,
  output logic              alu_c_in,
  output logic [3:0]        cc
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] ir_q;
  logic [3:0]        cc_q;
  logic [2:0]        opc;
  logic              taken;
  logic              accept;
  logic              ir_we, cc_we;
  logic              ren_d, wen_d, addr_sel_d, pc_inc_d, pc_load_d;
  logic              reg_wen_d, wdata_sel_d, imm_sel_d;
  logic [2:0]        alu_func_d;

  assign opc = ir_q[OPC_HI:OPC_LO];

`ifdef STUMP_MEM_WAIT_EN
  assign accept = bus.mem_ack;
`else
  // Every access completes at once; mem_ack is folded in only so it is read.
  assign accept = bus.mem_ack | 1'b1;
`endif

  stump_cond_eval u_cond_eval (
    .cc    (cc_q),
    .cond  (ir_q[COND_HI:COND_LO]),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cc_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (ir_we) ir_q <= bus.mem_rdata;
      if (cc_we) cc_q <= alu_flags;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    cc_we       = 1'b0;
    ren_d       = 1'b0;
    wen_d       = 1'b0;
    addr_sel_d  = 1'b0;
    pc_inc_d    = 1'b0;
    pc_load_d   = 1'b0;
    reg_wen_d   = 1'b0;
    wdata_sel_d = 1'b0;
    imm_sel_d   = 1'b0;
    alu_func_d  = 3'b000;
    case (state_q)
      ST_FETCH: begin
        ren_d = 1'b1;
        if (accept) begin
          ir_we    = 1'b1;
          pc_inc_d = 1'b1;
          state_d  = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (opc == OP_BCC) begin
          // Only the immediate form of opcode 111 is a conditional branch.
          pc_load_d = ir_q[TYPE_BIT] & taken;
        end else if (opc == OP_LDST) begin
          imm_sel_d = ir_q[TYPE_BIT];
          state_d   = ST_MEMORY;
        end else begin
          alu_func_d = opc;
          imm_sel_d  = ir_q[TYPE_BIT];
          reg_wen_d  = 1'b1;
          cc_we      = ir_q[S_BIT];
        end
      end
      ST_MEMORY: begin
        addr_sel_d = 1'b1;
        if (ir_q[S_BIT]) begin
          wen_d = 1'b1;
        end else begin
          ren_d       = 1'b1;
          reg_wen_d   = 1'b1;
          wdata_sel_d = 1'b1;
        end
        if (accept) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Gate every decoded control with rst_n so nothing is asserted during reset.
  assign bus.mem_ren  = ren_d & rst_n;
  assign bus.mem_wen  = wen_d & rst_n;
  assign bus.addr_sel = addr_sel_d & rst_n;
  assign pc_inc       = pc_inc_d & rst_n;
  assign pc_load      = pc_load_d & rst_n;
  assign reg_wen      = reg_wen_d & rst_n;
  assign wdata_sel    = wdata_sel_d & rst_n;
  assign imm_sel      = imm_sel_d & rst_n;
  assign alu_func     = alu_func_d & {3{rst_n}};

  assign state    = state_q;
  assign ir       = ir_q;
  assign cc       = cc_q;
  assign alu_c_in = cc_q[FLAG_C];
endmodule

// File: tb/tb_stump_control.sv
// tb_stump_control: self-checking bench for stump_control.
// Drives directed and random instructions through the memory bus and compares
// every cycle against an instruction-level model of the control unit.
// Honours STUMP_MEM_WAIT_EN by inserting mem_ack=0 cycles in FETCH/MEMORY.
module tb_stump_control;
  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_flags;
  logic [1:0]  state;
  logic [15:0] ir;
  logic        pc_inc, pc_load, reg_wen, wdata_sel, imm_sel, alu_c_in;
  logic [2:0]  alu_func;
  logic [3:0]  cc;

  stump_control_if bus ();

  stump_control #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_flags (alu_flags),
    .state     (state),
    .ir        (ir),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .reg_wen   (reg_wen),
    .wdata_sel (wdata_sel),
    .imm_sel   (imm_sel),
    .alu_func  (alu_func),
    .alu_c_in  (alu_c_in),
    .cc        (cc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  model_cc = 4'h0;
  logic [15:0] model_ir = 16'h0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Branch condition table, {N,Z,V,C}
  function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (cond)
      4'h0: return 1;
      4'h1: return 0;
      4'h2: return c && !z;
      4'h3: return !c || z;
      4'h4: return !c;
      4'h5: return c;
      4'h6: return !z;
      4'h7: return z;
      4'h8: return !v;
      4'h9: return v;
      4'hA: return !n;
      4'hB: return n;
      4'hC: return n == v;
      4'hD: return n != v;
      4'hE: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  // Hold mem_ack low for a few cycles; the access must not complete.
  task automatic wait_states(input logic [1:0] st);
`ifdef STUMP_MEM_WAIT_EN
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      alu_flags   = 4'($urandom);
      #1;
      check_val("wait_state", {14'h0, state}, {14'h0, st});
      check_val("wait_ir", ir, model_ir);
      check_val("wait_pc_inc", {15'h0, pc_inc}, 16'h0);
    end
`else
    st = st;
`endif
  endtask

  // ---------------- driver: one full instruction ----------------
  task automatic run_instr(input logic [15:0] instr, input logic [3:0] flags);
    logic [2:0]  op;
    logic [15:0] exp_ir;
    bit          alu_op;
    op     = instr[15:13];
    alu_op = (op <= 3'd5);
    bus.mem_rdata = instr;
    wait_states(2'd0);
    // FETCH
    @(negedge clk);
    bus.mem_rdata = instr;
    bus.mem_ack   = 1'b1;
`ifndef STUMP_MEM_WAIT_EN
    bus.mem_ack   = 1'($urandom);
`endif
    alu_flags = 4'($urandom);
    #1;
    check_val("f_state", {14'h0, state}, 16'd0);
    check_val("f_ren", {15'h0, bus.mem_ren}, 16'd1);
    check_val("f_addr_sel", {15'h0, bus.addr_sel}, 16'd0);
    check_val("f_pc_inc", {15'h0, pc_inc}, 16'd1);
    check_val("f_reg_wen", {15'h0, reg_wen}, 16'd0);
    exp_q.push_back(instr);
    // EXECUTE
    @(negedge clk);
    bus.mem_rdata = 16'($urandom);
    alu_flags     = flags;
    #1;
    exp_ir   = exp_q.pop_front();
    model_ir = exp_ir;
    check_val("x_state", {14'h0, state}, 16'd1);
    check_val("x_ir", ir, exp_ir);
    check_val("x_alu_func", {13'h0, alu_func}, alu_op ? {13'h0, op} : 16'd0);
    check_val("x_imm_sel", {15'h0, imm_sel}, (op != 3'd7) ? {15'h0, instr[12]} : 16'd0);
    check_val("x_reg_wen", {15'h0, reg_wen}, {15'h0, alu_op});
    check_val("x_wdata_sel", {15'h0, wdata_sel}, 16'd0);
    check_val("x_pc_load", {15'h0, pc_load},
              {15'h0, (op == 3'd7) && instr[12] && cond_true(instr[11:8], model_cc)});
    check_val("x_pc_inc", {15'h0, pc_inc}, 16'd0);
    check_val("x_mem_strobes", {14'h0, bus.mem_ren, bus.mem_wen}, 16'd0);
    check_val("x_cc", {12'h0, cc}, {12'h0, model_cc});
    check_val("x_c_in", {15'h0, alu_c_in}, {15'h0, model_cc[0]});
    if (alu_op && instr[11]) model_cc = flags;
    // MEMORY
    if (op == 3'd6) begin
      wait_states(2'd2);
      @(negedge clk);
      bus.mem_ack = 1'b1;
      alu_flags   = 4'($urandom);
      #1;
      check_val("m_state", {14'h0, state}, 16'd2);
      check_val("m_addr_sel", {15'h0, bus.addr_sel}, 16'd1);
      check_val("m_ren", {15'h0, bus.mem_ren}, {15'h0, !instr[11]});
      check_val("m_wen", {15'h0, bus.mem_wen}, {15'h0, instr[11]});
      check_val("m_reg_wen", {15'h0, reg_wen}, {15'h0, !instr[11]});
      check_val("m_wdata_sel", {15'h0, wdata_sel}, {15'h0, !instr[11]});
      check_val("m_cc", {12'h0, cc}, {12'h0, model_cc});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, {14'h0, state}, 16'd0);
    check_val({tag, "_cc"}, {12'h0, cc}, 16'd0);
    check_val({tag, "_ir"}, ir, 16'd0);
    check_val({tag, "_strobes"},
              {9'h0, bus.mem_ren, bus.mem_wen, pc_inc, pc_load, reg_wen, wdata_sel, imm_sel},
              16'd0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[15:13] == 3'd7) r[12] = 1'b1;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst_n         = 1'b0;
    alu_flags     = 4'h0;
    bus.mem_rdata = 16'h0;
    bus.mem_ack   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases
    run_instr(16'h1A24, 4'b0100);  // ADDS imm -> cc = 0100
    run_instr(16'h1224, 4'b1011);  // ADD imm, S=0: cc unchanged
    run_instr(16'hF705, 4'h0);     // BEQ taken
    run_instr(16'hF605, 4'h0);     // BNE not taken
    run_instr(16'hF005, 4'h0);     // BAL taken
    run_instr(16'hF105, 4'h0);     // BNV not taken
    run_instr(16'hC328, 4'h0);     // LD
    run_instr(16'hCB28, 4'h0);     // ST
    run_instr(16'h0800, 4'b1001);  // ADDS reg -> cc = 1001
    run_instr(16'hF205, 4'h0);     // BHI immediately after S: C=1,Z=0 -> taken

    for (int i = 0; i < 150; i++) run_instr(rand_instr(), 4'($urandom));

    // Reset in the middle of EXECUTE
    run_instr(16'h0800, 4'b1111);
    @(negedge clk);
    bus.mem_rdata = 16'h0A00;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    #1;
    check_val("pre_rst_state", {14'h0, state}, 16'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    #1;
    check_reset_outputs("hold_rst");
    model_cc = 4'h0;
    model_ir = 16'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run_instr(rand_instr(), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stump_control.md
# stump_control

Control unit and condition-code store for the Stump 16-bit processor. It sits beside the ALU and closes the loop around it: it decodes the instruction register into the ALU `func`/`c_in` and datapath enables. It latches the ALU `flags_out` into the CC register and evaluates `Bcc` conditions from that register. It sequences each instruction through a fetch/execute/memory state machine with a memory handshake.

## Interface
Parameters:
- `DATA_W`, 16: instruction/data width; only 16 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_rdata`  in  16  memory read data; the instruction in FETCH.
- `mem_ack`  in  1  memory access complete (used only with `STUMP_MEM_WAIT_EN`).
- `alu_flags`  in  4  ALU `{N,Z,V,C}`.
- `state`  out  2  FETCH=0, EXECUTE=1, MEMORY=2.
- `ir`  out  16  instruction register.
- `mem_ren` / `mem_wen`  out  1  memory read / write strobe.
- `addr_sel`  out  1  0: address is PC; 1: address is ALU result.
- `pc_inc`  out  1  PC (R7) increment.
- `pc_load`  out  1  PC load from ALU (branch taken).
- `reg_wen`  out  1  register-bank write.
- `wdata_sel`  out  1  0: write-back data is ALU; 1: write-back data is `mem_rdata`.
- `imm_sel`  out  1  ALU operand B is a sign-extended immediate.
- `alu_func`  out  3  ALU function.
- `alu_c_in`  out  1  equals `cc[0]`.
- `cc`  out  4  CC register `{N,Z,V,C}`.

## Operation
Instruction fields:
- `ir[15:13]` is the opcode.
- `ir[12]` is the type (1 = immediate).
- `ir[11]` is S for ALU ops and L/S for LD/ST (0 = LD).
- Bcc is opcode 111 with `ir[12]=1`; its condition is `ir[11:8]`.

State machine:
- **FETCH**
  - Asserts `mem_ren`, `addr_sel=0`.
  - On acceptance: loads `ir<=mem_rdata`, pulses `pc_inc`, moves to EXECUTE.
- **EXECUTE**
  - ALU ops (000–101): `alu_func=ir[15:13]`, `reg_wen=1`, `wdata_sel=0`; `cc<=alu_flags` iff S=1; next state FETCH.
  - LD/ST (110): `alu_func=000` (address add); next state MEMORY. CC is never written.
  - Bcc (111): `alu_func=000` (PC+offset); `pc_load` = condition true; next state FETCH.
- **MEMORY**
  - Drives `addr_sel=1`.
  - LD: `mem_ren=1`, `reg_wen=1`, `wdata_sel=1`.
  - ST: `mem_wen=1`.
  - On acceptance, moves to FETCH.
- The unused encoding 3 goes to FETCH.

Other rules:
- `imm_sel = ir[12]` in EXECUTE for opcodes other than 111.
- Condition codes 0–F: AL, NV, HI (C & ~Z), LS (~C | Z), CC (~C), CS (C), NE, EQ, VC, VS, PL, MI, GE (N==V), LT (N!=V), GT (~Z & N==V), LE (Z | N!=V).
- All strobes are decoded combinationally from `state` and `ir` and are 0 outside their state.
- The CC write and the Bcc evaluation never collide, since Bcc never has S.

## Timing
- Reset (async, `rst_n`=0):
  - `state`=FETCH, `ir`=16'h0000, `cc`=4'h0.
  - All strobes and enables are forced to 0 while `rst_n` is low.
- Reset mid-instruction abandons the instruction; no write strobe survives.
- Without wait states, each instruction takes 2 cycles (ALU, Bcc) or 3 cycles (LD/ST).
- `cc` updates on the rising edge that ends EXECUTE and is visible the next cycle. A Bcc immediately after an S-instruction sees the new flags.
- `alu_c_in` reflects the registered `cc[0]` and never the current `alu_flags`.

## Configuration
- `STUMP_MEM_WAIT_EN` defined:
  - FETCH and MEMORY hold their state and strobes until a cycle with `mem_ack=1`.
  - `ir` loads and `pc_inc` fires only in the `mem_ack` cycle.
- Not defined:
  - `mem_ack` is ignored, and every FETCH and MEMORY completes in one cycle.

## Structure
- Package `stump_pkg`:
  - state encodings;
  - opcode constants (ADD…BCC);
  - condition-code constants;
  - field index constants.
- Sub-module `stump_cond_eval`: combinational, takes `cc` and `cond[3:0]`, returns `taken`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXECUTE → `state`=0, `cc`=0, all strobes 0 immediately; FETCH resumes on the first edge after release.
- **ADDS:** fetch 16'h1A24 with `alu_flags`=4'b0100 → EXECUTE `alu_func`=000, `imm_sel`=1, `reg_wen`=1; `cc`=4'b0100 next cycle. The same instruction with S=0 (16'h1224) leaves `cc` unchanged.
- **Branch:**
  - With `cc`=4'b0100, fetch BEQ 16'hF705 → `pc_load`=1; BNE 16'hF605 → `pc_load`=0.
  - BAL 16'hF005 → taken; BNV 16'hF105 → not taken.
- **LD:** fetch 16'hC328 → FETCH, EXECUTE, MEMORY with `mem_ren`=1, `addr_sel`=1, `wdata_sel`=1, `reg_wen`=1; 3 cycles total.
- **ST:** fetch 16'hCB28 → MEMORY with `mem_wen`=1, `reg_wen`=0.
- **Wait states (`STUMP_MEM_WAIT_EN`):** hold `mem_ack`=0 for 3 cycles in FETCH → `state` stays 0, `ir` unchanged, `pc_inc`=0; on `mem_ack`=1, `ir` loads and `pc_inc` pulses once.
